// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//
// Bank of N_CH independent programmable clock dividers sharing one clock.
// Each channel counts enabled cycles up to its active divisor. At that point
// it emits a one-cycle tick and toggles its square-wave output, so:
//   - tick period    = act_div + 1 cycles
//   - clk_out period = 2 * (act_div + 1) cycles, 50% duty
//
// A divisor written while a channel is running goes to a shadow register.
// It takes effect at the channel's next terminal count, so the output never
// glitches mid-period. A divisor written while the channel is disabled takes
// effect on the next cycle.
//
// Ports
//   clk       in   sole clock, everything updates on its rising edge
//   rst       in   synchronous active-high reset, highest priority
//   en        in   [N_CH]  per-channel count enable
//   sync_clr  in   phase-align pulse: restarts every channel from zero
//   cfg_we    in   single-cycle divisor write strobe
//   cfg_ch    in   [4]     channel targeted by cfg_we (>= N_CH is ignored)
//   cfg_div   in   [CNT_W] divisor value carried by cfg_we
//   clk_out   out  [N_CH]  registered square wave per channel
//   tick      out  [N_CH]  registered terminal-count pulse per channel
//   cfg_pend  out  [N_CH]  channel holds a written, not yet applied divisor
// ---------------------------------------------------------------------------
module clk_div_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 1_579_993
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync_clr,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  cfg_pend
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] pend_div;
        logic             pend;
        logic             out_q;
        logic             tick_q;
        logic             wr;
        logic             term;

        // cfg_ch is only four bits and i < N_CH, so an index at or beyond
        // N_CH never matches any channel and the write is dropped.
        assign wr = cfg_we && (cfg_ch == 4'(i));

        // The comparison is >= rather than ==. If a retune lowers the divisor
        // below the running count, the channel still terminates on its next
        // enabled cycle instead of wrapping through the full counter range.
        assign term = en[i] && (cnt >= act_div);

        // Channel state. The config write is placed last in the block so its
        // nonblocking assignments take precedence over the clear and terminal
        // actions in the same cycle. As a result:
        //   - A write that coincides with a terminal count lands in the shadow
        //     register after the old shadow value has been applied, and pend
        //     stays set.
        //   - A write that coincides with sync_clr is applied after the clear.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt      <= '0;
                act_div  <= RESET_DIV;
                pend_div <= RESET_DIV;
                pend     <= 1'b0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                if (sync_clr) begin
                    cnt    <= '0;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend) begin
                        act_div <= pend_div;
                    end
                    pend <= 1'b0;
                end else if (term) begin
                    cnt    <= '0;
                    out_q  <= ~out_q;
                    tick_q <= 1'b1;
                    if (pend) begin
                        act_div <= pend_div;
                        pend    <= 1'b0;
                    end
                end else begin
                    tick_q <= 1'b0;
                    if (en[i]) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                if (wr) begin
                    if (en[i]) begin
                        pend_div <= cfg_div;
                        pend     <= 1'b1;
                    end else begin
                        act_div <= cfg_div;
                        pend    <= 1'b0;
                    end
                end
            end
        end

        assign clk_out[i]  = out_q;
        assign tick[i]     = tick_q;
        assign cfg_pend[i] = pend;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
//
// Self-checking bench for clk_div_multi, built with a small reset divisor so
// that the timing from reset release is short enough to observe.
//
// There are two kinds of test:
//   - Directed scenarios that derive the expected tick and clk_out patterns
//     arithmetically from the divisor.
//   - A randomized run compared every cycle against a behavioural channel
//     model.
//
// Inputs change 1 time unit after the rising edge. Outputs are sampled at
// the same point.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;
    localparam int DEF   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  en;
    logic             sync_clr;
    logic             cfg_we;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  cfg_pend;

    int checks = 0;
    int errors = 0;

    // Behavioural view of each channel:
    //   m_pos   - enabled cycles elapsed in the current half period
    //   m_div   - divisor in force
    //   m_next  - divisor queued for the next half period
    //   m_queued, m_wave, m_pulse - mirror cfg_pend, clk_out and tick
    int m_pos   [N_CH];
    int m_div   [N_CH];
    int m_next  [N_CH];
    bit m_queued[N_CH];
    bit m_wave  [N_CH];
    bit m_pulse [N_CH];

    always #5 clk = ~clk;

    clk_div_multi #(
        .N_CH(N_CH),
        .CNT_W(CNT_W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sync_clr(sync_clr),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .clk_out(clk_out),
        .tick(tick),
        .cfg_pend(cfg_pend)
    );

    // Advance the model by one clock using the inputs present at the edge.
    function automatic void model_step();
        bit hit;
        bit half_done;
        for (int c = 0; c < N_CH; c++) begin
            hit = cfg_we && (int'(cfg_ch) == c);
            if (rst) begin
                m_pos[c]    = 0;
                m_div[c]    = DEF;
                m_next[c]   = DEF;
                m_queued[c] = 0;
                m_wave[c]   = 0;
                m_pulse[c]  = 0;
            end else begin
                half_done = en[c] && (m_pos[c] >= m_div[c]);
                m_pulse[c] = 0;
                if (sync_clr) begin
                    m_pos[c]  = 0;
                    m_wave[c] = 0;
                    if (m_queued[c]) m_div[c] = m_next[c];
                    m_queued[c] = 0;
                end else if (half_done) begin
                    m_pos[c]   = 0;
                    m_wave[c]  = !m_wave[c];
                    m_pulse[c] = 1;
                    if (m_queued[c]) begin
                        m_div[c]    = m_next[c];
                        m_queued[c] = 0;
                    end
                end else if (en[c]) begin
                    m_pos[c] = m_pos[c] + 1;
                end
                if (hit && en[c]) begin
                    m_next[c]   = int'(cfg_div);
                    m_queued[c] = 1;
                end else if (hit) begin
                    m_div[c]    = int'(cfg_div);
                    m_queued[c] = 0;
                end
            end
        end
    endfunction

    // One clock: the model follows the edge, then outputs settle for sampling.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_cfg(input int ch, input int dv);
        cfg_we  = 1'b1;
        cfg_ch  = 4'(ch);
        cfg_div = CNT_W'(dv);
        step();
        cfg_we  = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = '0;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst      = 1'b1;
        en       = '1;
        sync_clr = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 4'd0;
        cfg_div  = CNT_W'(2);
        step();
        step();
        checks++;
        if ({clk_out, tick, cfg_pend} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got %b required 0", {clk_out, tick, cfg_pend});
        end
        cfg_we   = 1'b0;
        sync_clr = 1'b0;
        rst      = 1'b0;
        n = 0;
        for (int k = 1; k <= DEF + 5 && n == 0; k++) begin
            step();
            if (tick[0]) n = k;
        end
        checks++;
        if (n != DEF + 1) begin
            errors++;
            $display("[TB] FAIL first_tick_latency got %0d required %0d", n, DEF + 1);
        end
        checks++;
        if (tick !== '1) begin
            errors++;
            $display("[TB] FAIL first_tick_all got %b required 1111", tick);
        end
    endtask

    task automatic test_div3();
        do_reset();
        write_cfg(0, 3);
        checks++;
        if (cfg_pend[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div3_direct_pend got %b required 0", cfg_pend[0]);
        end
        en = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (tick[0] !== (k % 4 == 0) || clk_out[0] !== ((k / 4) % 2 == 1)) begin
                errors++;
                $display("[TB] FAIL div3_wave cyc%0d got tick=%b clk=%b required tick=%b clk=%b",
                         k, tick[0], clk_out[0], (k % 4 == 0), ((k / 4) % 2 == 1));
            end
        end
    endtask

    task automatic test_div0();
        int n;
        logic prev;
        do_reset();
        en = 4'b0010;
        step();
        step();
        write_cfg(1, 0);
        checks++;
        if (cfg_pend[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL div0_pend_set got %b required 1", cfg_pend[1]);
        end
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            step();
            if (tick[1]) n = k;
        end
        checks++;
        if (n != DEF - 2) begin
            errors++;
            $display("[TB] FAIL div0_apply_tick got %0d required %0d", n, DEF - 2);
        end
        checks++;
        if (cfg_pend[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div0_pend_clear got %b required 0", cfg_pend[1]);
        end
        for (int k = 0; k < 6; k++) begin
            prev = clk_out[1];
            step();
            checks++;
            if (tick[1] !== 1'b1 || clk_out[1] !== ~prev) begin
                errors++;
                $display("[TB] FAIL div0_toggle cyc%0d got tick=%b clk=%b required tick=1 clk=%b",
                         k, tick[1], clk_out[1], ~prev);
            end
        end
    endtask

    task automatic test_retune();
        int n;
        do_reset();
        write_cfg(2, 9);
        en = 4'b0100;
        for (int k = 0; k < 5; k++) step();
        write_cfg(2, 2);
        checks++;
        if (cfg_pend[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL retune_pend_set got %b required 1", cfg_pend[2]);
        end
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            step();
            if (tick[2]) n = k;
        end
        checks++;
        if (n != 4 || cfg_pend[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL retune_terminal got delay=%0d pend=%b required delay=4 pend=0", n, cfg_pend[2]);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (tick[2] !== (k % 3 == 0)) begin
                errors++;
                $display("[TB] FAIL retune_period cyc%0d got %b required %b", k, tick[2], (k % 3 == 0));
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        write_cfg(0, 3);
        en = 4'b0001;
        step();
        step();
        en = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pause_hold cyc%0d got tick=%b clk=%b required 0 0", k, tick[0], clk_out[0]);
            end
        end
        en = 4'b0001;
        step();
        checks++;
        if (tick[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_resume1 got %b required 0", tick[0]);
        end
        step();
        checks++;
        if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_resume2 got tick=%b clk=%b required 1 1", tick[0], clk_out[0]);
        end
    endtask

    task automatic test_sync_clr();
        int divs[N_CH];
        int p;
        bit et;
        bit ec;
        divs = '{1, 2, 4, 7};
        do_reset();
        for (int c = 0; c < N_CH; c++) write_cfg(c, divs[c]);
        en = '1;
        for (int k = $urandom_range(5, 20); k > 0; k--) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        checks++;
        if (clk_out !== '0 || tick !== '0) begin
            errors++;
            $display("[TB] FAIL sync_clr_state got clk=%b tick=%b required 0 0", clk_out, tick);
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            for (int c = 0; c < N_CH; c++) begin
                p  = divs[c] + 1;
                et = (k % p == 0);
                ec = ((k / p) % 2 == 1);
                checks++;
                if (tick[c] !== et || clk_out[c] !== ec) begin
                    errors++;
                    $display("[TB] FAIL sync_align ch%0d cyc%0d got tick=%b clk=%b required tick=%b clk=%b",
                             c, k, tick[c], clk_out[c], et, ec);
                end
            end
        end
    endtask

    task automatic test_rst_cfg();
        int n;
        en = '1;
        for (int k = 0; k < 9; k++) step();
        rst     = 1'b1;
        cfg_we  = 1'b1;
        cfg_ch  = 4'd3;
        cfg_div = CNT_W'(11);
        step();
        cfg_ch  = 4'd5;
        cfg_div = CNT_W'(1);
        step();
        cfg_we = 1'b0;
        checks++;
        if ({clk_out, tick, cfg_pend} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_cfg_state got %b required 0", {clk_out, tick, cfg_pend});
        end
        rst = 1'b0;
        en  = '0;
        write_cfg(5, 1);
        checks++;
        if (cfg_pend !== '0) begin
            errors++;
            $display("[TB] FAIL bad_ch_pend got %b required 0", cfg_pend);
        end
        en = '1;
        n  = 0;
        for (int k = 1; k <= DEF + 5 && n == 0; k++) begin
            step();
            if (tick[0]) n = k;
        end
        checks++;
        if (n != DEF + 1 || tick !== '1) begin
            errors++;
            $display("[TB] FAIL rst_cfg_default got delay=%0d tick=%b required delay=%0d tick=1111", n, tick, DEF + 1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 149) == 0);
            sync_clr = ($urandom_range(0, 39) == 0);
            en       = N_CH'($urandom | $urandom);
            cfg_we   = ($urandom_range(0, 4) == 0);
            cfg_ch   = 4'($urandom_range(0, 7));
            cfg_div  = CNT_W'($urandom_range(0, 9));
            step();
            for (int c = 0; c < N_CH; c++) begin
                checks++;
                if (clk_out[c] !== m_wave[c] || tick[c] !== m_pulse[c] || cfg_pend[c] !== m_queued[c]) begin
                    errors++;
                    $display("[TB] FAIL random ch%0d cyc%0d got clk/tick/pend=%b%b%b required %b%b%b",
                             c, k, clk_out[c], tick[c], cfg_pend[c], m_wave[c], m_pulse[c], m_queued[c]);
                end
            end
        end
        rst      = 1'b0;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = '0;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = 4'd0;
        cfg_div  = '0;
        test_reset();
        test_div3();
        test_div0();
        test_retune();
        test_pause();
        test_sync_clr();
        test_rst_cfg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 The block SHALL take parameter N_CH, default 4, as the number of independent divider channels (1..16).
REQ-002 The block SHALL take parameter CNT_W, default 32, as the width of each channel counter and divisor.
REQ-003 The block SHALL take parameter DEFAULT_DIV, default 1_579_993, as the reset-time divisor of every channel.
REQ-004 clk  input  1  sole clock; all state SHALL update on posedge clk only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  N_CH  per-channel count enable.
REQ-007 sync_clr  input  1  phase-align pulse for all channels.
REQ-008 cfg_we  input  1  divisor write strobe, single cycle.
REQ-009 cfg_ch  input  4  target channel index for cfg_we.
REQ-010 cfg_div  input  CNT_W  divisor value written by cfg_we.
REQ-011 clk_out  output  N_CH  per-channel registered square wave.
REQ-012 tick  output  N_CH  per-channel registered one-cycle terminal-count pulse.
REQ-013 cfg_pend  output  N_CH  high while a channel holds a written but not yet applied divisor.

Function
REQ-014 Each channel SHALL hold cnt (CNT_W), active divisor act_div, shadow divisor pend_div and a pend flag.
REQ-015 Terminal condition for channel i SHALL be en[i] AND cnt >= act_div; comparison unsigned, full CNT_W.
REQ-016 On terminal: cnt <= 0, clk_out[i] <= ~clk_out[i], tick[i] <= 1, and act_div <= pend_div with pend cleared if pend set.
REQ-017 When en[i] high and not terminal: cnt <= cnt + 1, tick[i] <= 0, clk_out[i] holds.
REQ-018 When en[i] low: cnt, clk_out[i] and act_div SHALL hold, and tick[i] <= 0. Re-enabling SHALL resume from the held count.
REQ-019 Timing SHALL be: tick period = act_div+1 cycles; clk_out period = 2*(act_div+1) cycles; 50% duty.
REQ-020 act_div = 0 SHALL give tick high every cycle and clk_out toggling every cycle.
REQ-021 cfg_we with cfg_ch >= N_CH SHALL be ignored.
REQ-022 cfg_we to a channel with en low SHALL load act_div directly next cycle and clear pend. cnt is untouched.
REQ-023 cfg_we to a channel with en high SHALL load pend_div and set pend, applied at the next terminal (glitch-free retune).
REQ-024 cfg_we in the same cycle as that channel's terminal SHALL go to pend_div, apply at the following terminal, and leave pend set.
REQ-025 A second cfg_we before apply SHALL overwrite pend_div. Only the last value applies.
REQ-026 If act_div is lowered below the current cnt, the next enabled cycle SHALL be terminal (>= rule); cnt never wraps through 2^CNT_W.
REQ-027 sync_clr SHALL, for all channels: cnt <= 0, clk_out <= 0, tick <= 0, and apply any pending divisor (pend cleared). It overrides terminal/count actions.
REQ-028 A cfg_we coincident with sync_clr SHALL be applied after the clear, using the en-state rule (REQ-022/023).
REQ-029 All outputs SHALL be driven directly from flops; cfg_pend[i] = pend flag.

Reset
REQ-030 rst SHALL set cnt = 0, act_div = pend_div = DEFAULT_DIV, pend = 0, clk_out = 0, tick = 0, and cfg_pend = 0 on every channel.
REQ-031 rst SHALL take priority over sync_clr, cfg_we and counting. Mid-period reset SHALL restart the phase from 0.
REQ-032 The first tick after rst release with en high SHALL occur DEFAULT_DIV+1 cycles after release.

Verification
REQ-033 Run rst, write div=3 on ch0 with en=0, then set en0=1 -> tick0 every 4 cycles; clk_out0 high 4 / low 4.
REQ-034 Write div=0 on ch1 with en=1 -> applies at ch1's next terminal; afterwards tick1 is constant 1 and clk_out1 toggles each cycle.
REQ-035 With ch2 at div=9, enabled, and cnt=5, write div=2 -> cfg_pend2=1; terminal occurs at cnt=9; next period is 3 cycles; cfg_pend2=0.
REQ-036 With ch0 at div=3, drop en0 at cnt=2 for 10 cycles, then re-enable -> tick0 is 0 while disabled; the next tick comes 2 cycles after re-enable.
REQ-037 Run ch0..3 with divs 1, 2, 4, 7, pulse sync_clr -> all cnt=0 and clk_out=0 next cycle; tick edges are then phase-aligned to the clear.
REQ-038 Assert rst during cfg_we to ch3 with cfg_ch=5 also attempted -> all channels show the REQ-030 state; the cfg_ch=5 write has no effect.
